// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit core: owns PC, a 4-entry
// register file and the zero/carry flags, and drives an external combinational ALU.
module alu_sequencer #(
  parameter int         NUM_REGS = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [3:0] alu_mode,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       flag_zero,
  output logic       flag_carry,
  output logic       halted,
  output logic       busy,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_IMM, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t r_state;
  state_t w_next_state;

  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_addr;
  logic [7:0] r_in1;
  logic [7:0] r_in2;
  logic [3:0] r_mode;
  logic       r_zero;
  logic       r_carry;
  logic [7:0] r_regs [NUM_REGS];

  logic [3:0]          w_dec_op;
  logic [3:0]          w_ir_op;
  logic                w_take;
  logic                w_we;
  logic [1:0]          w_wsel;
  logic [7:0]          w_wdata;
  logic [NUM_REGS-1:0] w_hit;

  assign w_dec_op = imem_data[7:4];
  assign w_ir_op  = r_ir[7:4];
  assign w_take   = (w_ir_op == OP_JMP) ||
                    (w_ir_op == OP_JZ && r_zero) ||
                    (w_ir_op == OP_JC && r_carry);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    halted       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_FETCH;
      end
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_dec_op >= OP_ADD && w_dec_op <= OP_XOR)      w_next_state = S_EXEC;
        else if (w_dec_op >= OP_LDI && w_dec_op <= OP_JMP) w_next_state = S_FETCH_IMM;
        else if (w_dec_op == OP_HLT)                       w_next_state = S_HALT;
        else                                               w_next_state = S_FETCH;
      end
      S_FETCH_IMM: w_next_state = S_IMM;
      S_IMM:       w_next_state = S_FETCH;
      S_EXEC:      w_next_state = S_WB;
      S_WB:        w_next_state = S_FETCH;
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Single register-file write port shared by MOV (decode), LDI (imm) and ALU write-back.
  always_comb begin
    w_we    = 1'b0;
    w_wsel  = r_ir[3:2];
    w_wdata = alu_out;
    case (r_state)
      S_DECODE: begin
        if (w_dec_op == OP_MOV) begin
          w_we    = 1'b1;
          w_wsel  = imem_data[3:2];
          w_wdata = r_regs[imem_data[1:0]];
        end
      end
      S_IMM: begin
        if (w_ir_op == OP_LDI) begin
          w_we    = 1'b1;
          w_wdata = imem_data;
        end
      end
      S_WB:    w_we = (w_ir_op != OP_CMP);
      default: w_we = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_hit
    assign w_hit[gi] = w_we && (w_wsel == 2'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst)           r_regs[i] <= '0;
      else if (w_hit[i]) r_regs[i] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_addr  <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_mode  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH, S_FETCH_IMM: r_addr <= r_pc;
        S_DECODE: begin
          r_ir <= imem_data;
          r_pc <= r_pc + 8'd1;
        end
        S_IMM: r_pc <= w_take ? imem_data : r_pc + 8'd1;
        S_EXEC: begin
          r_in1  <= r_regs[r_ir[3:2]];
          r_in2  <= r_regs[r_ir[1:0]];
          r_mode <= w_ir_op - 4'd1;
        end
        // Logical ops have no meaningful carry, so it is forced clear.
        S_WB: begin
          r_zero  <= alu_zero;
          r_carry <= (w_ir_op <= OP_CMP) ? alu_carry : 1'b0;
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign imem_addr  = r_addr;
  assign alu_in1    = r_in1;
  assign alu_in2    = r_in2;
  assign alu_mode   = r_mode;
  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
  assign dbg_data   = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: an instruction-level model expands each program into a
// per-cycle expected trace that is compared against the DUT every cycle.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] imem_addr, imem_data;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic [3:0] alu_mode;
  logic       alu_zero, alu_carry;
  logic       flag_zero, flag_carry, halted, busy;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int tests = 0;
  int fails = 0;

  alu_sequencer #(.NUM_REGS(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .halted(halted), .busy(busy),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  assign imem_data = rom[imem_addr];

  // Reference ALU: returns {zero, carry, result}; carry is borrow for SUB/CMP.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    logic [8:0] s;
    logic [7:0] o;
    logic       c;
    c = 1'b0;
    o = 8'h00;
    case (m)
      4'd0:       begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; end
      4'd1, 4'd2: begin o = a - b; c = (a < b); end
      4'd3:       o = a & b;
      4'd4:       o = a | b;
      4'd5:       o = a ^ b;
      default:    o = 8'h00;
    endcase
    return {(o == 8'h00), c, o};
  endfunction

  assign {alu_zero, alu_carry, alu_out} = alu_f(alu_in1, alu_in2, alu_mode);

  typedef struct packed {
    logic [7:0]      addr;
    logic            halted;
    logic            busy;
    logic            fz;
    logic            fc;
    logic [7:0]      a1;
    logic [7:0]      a2;
    logic [3:0]      mode;
    logic [3:0][7:0] r;
  } rec_t;

  rec_t       exp_q [$];
  int         exp_idx;
  logic [7:0] m_r [4];
  logic       m_z, m_c;
  logic [7:0] m_pc, m_addr, m_a1, m_a2;
  logic [3:0] m_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic h, input logic b);
    rec_t e;
    e.addr = m_addr; e.halted = h; e.busy = b; e.fz = m_z; e.fc = m_c;
    e.a1 = m_a1; e.a2 = m_a2; e.mode = m_mode;
    for (int i = 0; i < 4; i++) e.r[i] = m_r[i];
    exp_q.push_back(e);
  endtask

  // Executes the ROM program architecturally and records one entry per clock cycle.
  task automatic build_model(input int extra_halt);
    logic [7:0] ir, imm;
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [9:0] a;
    bit         done;
    exp_q.delete();
    exp_idx = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z = 1'b0; m_c = 1'b0; m_pc = 8'h00; m_addr = 8'h00;
    m_a1 = 8'h00; m_a2 = 8'h00; m_mode = 4'h0;
    push(1'b0, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      ir = rom[m_pc]; op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
      push(1'b0, 1'b1);
      m_addr = m_pc; m_pc = m_pc + 8'd1;
      push(1'b0, 1'b1);
      if (op == 4'hF) begin
        for (int j = 0; j < extra_halt; j++) push(1'b1, 1'b0);
        done = 1'b1;
      end else if (op == 4'h7) begin
        m_r[rd] = m_r[rs];
      end else if (op >= 4'h1 && op <= 4'h6) begin
        push(1'b0, 1'b1);
        m_a1 = m_r[rd]; m_a2 = m_r[rs]; m_mode = op - 4'd1;
        push(1'b0, 1'b1);
        a = alu_f(m_a1, m_a2, m_mode);
        if (op != 4'h3) m_r[rd] = a[7:0];
        m_z = a[9];
        m_c = (op <= 4'h3) ? a[8] : 1'b0;
      end else if (op >= 4'h8 && op <= 4'hB) begin
        push(1'b0, 1'b1);
        m_addr = m_pc; imm = rom[m_pc]; m_pc = m_pc + 8'd1;
        push(1'b0, 1'b1);
        case (op)
          4'h8:    m_r[rd] = imm;
          4'h9:    if (m_z) m_pc = imm;
          4'hA:    if (m_c) m_pc = imm;
          default: m_pc = imm;
        endcase
      end
    end
  endtask

  task automatic compare_cycle();
    rec_t e;
    e = exp_q[exp_idx];
    exp_idx++;
    chk("imem_addr", 32'(imem_addr), 32'(e.addr));
    chk("halted", 32'(halted), 32'(e.halted));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("flag_zero", 32'(flag_zero), 32'(e.fz));
    chk("flag_carry", 32'(flag_carry), 32'(e.fc));
    chk("alu_in1", 32'(alu_in1), 32'(e.a1));
    chk("alu_in2", 32'(alu_in2), 32'(e.a2));
    chk("alu_mode", 32'(alu_mode), 32'(e.mode));
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      chk($sformatf("R%0d", s), 32'(dbg_data), 32'(e.r[s]));
    end
  endtask

  task automatic rd_reg(input int s, output logic [7:0] v);
    dbg_sel = 2'(s);
    #1;
    v = dbg_data;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // abort_at >= 0 asserts rst (with a coincident start) in that cycle and stops.
  task automatic run_prog(input bit pulse, input int abort_at, output int halt_cyc);
    int n;
    bit ab;
    n = 0; ab = 1'b0; halt_cyc = -1;
    @(posedge clk); #2 start = 1'b1;
    @(negedge clk); compare_cycle();
    @(posedge clk); #2 start = 1'b0;
    while (exp_idx < exp_q.size() && n < 1000) begin
      @(negedge clk);
      compare_cycle();
      if (n == abort_at) begin
        rst = 1'b1; start = 1'b1; ab = 1'b1;
      end else begin
        start = pulse && (n % 5 == 3);
      end
      @(posedge clk); #1;
      n++;
      if (halted && halt_cyc < 0) halt_cyc = n;
      if (ab) break;
    end
    if (!ab && exp_idx < exp_q.size()) begin
      fails++;
      $display("FAIL timeout: got %0d cycles required trace of %0d", n, exp_q.size());
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  int         hc;
  logic [7:0] v;

  initial begin
    rst = 1'b1; start = 1'b0; dbg_sel = 2'd0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_flags", 32'({flag_zero, flag_carry}), 32'd0);
    rst = 1'b0;

    // LDI R0,5; LDI R1,3; ADD R0,R1; HLT
    clear_rom();
    rom[0] = 8'h81; rom[1] = 8'h05; rom[2] = 8'h85; rom[3] = 8'h03; rom[4] = 8'h11; rom[5] = 8'hF0;
    do_reset(); build_model(4); run_prog(1'b1, -1, hc);
    chk("p1_halt_cycles", 32'(hc), 32'd14);
    rd_reg(0, v); chk("p1_R0", 32'(v), 32'h08);
    rd_reg(1, v); chk("p1_R1", 32'(v), 32'h03);
    chk("p1_flags", 32'({flag_zero, flag_carry}), 32'd0);

    // Carry/zero from FF+01, JMP to FF, NOP at FF wraps to 00, JC and JZ taken.
    clear_rom();
    rom[8'h00] = 8'hA0; rom[8'h01] = 8'h10; rom[8'h02] = 8'h80; rom[8'h03] = 8'hFF;
    rom[8'h04] = 8'h84; rom[8'h05] = 8'h01; rom[8'h06] = 8'h11; rom[8'h07] = 8'hB0;
    rom[8'h08] = 8'hFF; rom[8'hFF] = 8'h00; rom[8'h10] = 8'h90; rom[8'h11] = 8'h20;
    do_reset(); build_model(3); run_prog(1'b1, -1, hc);
    rd_reg(0, v); chk("p2_R0", 32'(v), 32'h00);
    chk("p2_flags", 32'({flag_zero, flag_carry}), 32'b11);
    chk("p2_halt_addr", 32'(imem_addr), 32'h20);

    // CMP R2,R3 with 3<7; JZ falls through, JC taken.
    clear_rom();
    rom[0] = 8'h88; rom[1] = 8'h03; rom[2] = 8'h8C; rom[3] = 8'h07; rom[4] = 8'h3B;
    rom[5] = 8'h90; rom[6] = 8'h40; rom[7] = 8'hA0; rom[8] = 8'h40; rom[9] = 8'h00;
    do_reset(); build_model(3); run_prog(1'b1, -1, hc);
    rd_reg(2, v); chk("p3_R2", 32'(v), 32'h03);
    chk("p3_flags", 32'({flag_zero, flag_carry}), 32'b01);
    chk("p3_halt_addr", 32'(imem_addr), 32'h40);

    // JMP at FE with its operand at FF.
    clear_rom();
    rom[8'h00] = 8'hB0; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'hB0; rom[8'hFF] = 8'h30;
    do_reset(); build_model(2); run_prog(1'b0, -1, hc);
    chk("p4_halt_addr", 32'(imem_addr), 32'h30);

    // JMP at FF: operand is fetched from 00 (which holds B0).
    clear_rom();
    rom[8'h00] = 8'hB0; rom[8'h01] = 8'hFF; rom[8'hFF] = 8'hB0;
    do_reset(); build_model(2); run_prog(1'b0, -1, hc);
    chk("p5_halt_addr", 32'(imem_addr), 32'hB0);

    // XOR R1,R1 clears carry, MOVs keep flags, then AND/OR/SUB aliasing.
    clear_rom();
    rom[8'h00] = 8'h80; rom[8'h01] = 8'hFF; rom[8'h02] = 8'h84; rom[8'h03] = 8'h01;
    rom[8'h04] = 8'h11; rom[8'h05] = 8'h65; rom[8'h06] = 8'h7D; rom[8'h07] = 8'h7A;
    rom[8'h08] = 8'hC3; rom[8'h09] = 8'h80; rom[8'h0A] = 8'h0C; rom[8'h0B] = 8'h88;
    rom[8'h0C] = 8'h0A; rom[8'h0D] = 8'h42; rom[8'h0E] = 8'h58; rom[8'h0F] = 8'h20;
    do_reset(); build_model(3); run_prog(1'b1, -1, hc);
    rd_reg(1, v); chk("p6_R1", 32'(v), 32'h00);
    rd_reg(3, v); chk("p6_R3", 32'(v), 32'h00);
    rd_reg(2, v); chk("p6_R2", 32'(v), 32'h0A);
    chk("p6_flags", 32'({flag_zero, flag_carry}), 32'b10);

    // Reset (with coincident start) during WB of ADD R0,R1 drops the write.
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h05; rom[2] = 8'h84; rom[3] = 8'h03; rom[4] = 8'h11;
    do_reset(); build_model(1); run_prog(1'b0, 11, hc);
    chk("rwb_busy", 32'(busy), 32'd0);
    chk("rwb_halted", 32'(halted), 32'd0);
    chk("rwb_imem_addr", 32'(imem_addr), 32'd0);
    chk("rwb_flags", 32'({flag_zero, flag_carry}), 32'd0);
    chk("rwb_alu_in1", 32'(alu_in1), 32'd0);
    chk("rwb_alu_mode", 32'(alu_mode), 32'd0);
    for (int s = 0; s < 4; s++) begin
      rd_reg(s, v);
      chk($sformatf("rwb_R%0d", s), 32'(v), 32'd0);
    end
    @(posedge clk); #1;
    chk("rwb_stays_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
